// File: rtl/vrf_read_request_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vrf_read_request_rr_arbiter
// Description : Round-robin arbiter for N_IN vector-register-file read request
//               channels, feeding a single registered output slot. The slot
//               sustains one request per cycle when downstream keeps accepting.
//               Optional stall counter enabled by macro VRF_ARB_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_read_request_rr_arbiter #(
    parameter int N_IN  = 4,
    parameter int VS_W  = 5,
    parameter int SRC_W = 2,
    parameter int OFF_W = 6,
    parameter int IDX_W = 3,
    parameter int GW    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_IN-1:0]         io_in_valid,
    output logic [N_IN-1:0]         io_in_ready,
    input  logic [N_IN*VS_W-1:0]    io_in_bits_vs,
    input  logic [N_IN*SRC_W-1:0]   io_in_bits_readSource,
    input  logic [N_IN*OFF_W-1:0]   io_in_bits_offset,
    input  logic [N_IN*IDX_W-1:0]   io_in_bits_instructionIndex,
    input  logic                    io_out_ready,
    output logic                    io_out_valid,
    output logic [VS_W-1:0]         io_out_bits_vs,
    output logic [SRC_W-1:0]        io_out_bits_readSource,
    output logic [OFF_W-1:0]        io_out_bits_offset,
    output logic [IDX_W-1:0]        io_out_bits_instructionIndex,
`ifdef VRF_ARB_STALL_CNT_EN
    output logic [15:0]             io_stall_count,
`endif
    output logic [GW-1:0]           io_out_grant
);

    logic              r_full;
    logic [GW-1:0]     r_ptr;
    logic [GW-1:0]     r_grant;
    logic [VS_W-1:0]   r_vs;
    logic [SRC_W-1:0]  r_src;
    logic [OFF_W-1:0]  r_off;
    logic [IDX_W-1:0]  r_idx;

    logic              w_enq_ready;
    logic              w_win_found;
    logic [GW-1:0]     w_win;
    logic              w_enq;

    // The slot can take a new request when empty or when it drains this cycle.
    assign w_enq_ready = !r_full || io_out_ready;

    // Rotating priority search starting at the pointer; first valid channel wins.
    always_comb begin
        w_win_found = 1'b0;
        w_win       = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (!w_win_found && io_in_valid[(int'(r_ptr) + k) % N_IN]) begin
                w_win_found = 1'b1;
                w_win       = GW'((int'(r_ptr) + k) % N_IN);
            end
        end
    end

    // Enqueue only out of reset; this keeps in-flight requests from being lost silently.
    assign w_enq = reset && w_enq_ready && w_win_found;

    // One-hot accept toward the winning channel only.
    always_comb begin
        io_in_ready = '0;
        if (w_enq) begin
            io_in_ready[w_win] = 1'b1;
        end
    end

    // Output slot and pointer update; a simultaneous dequeue+enqueue keeps the slot full.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_full  <= 1'b0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_vs    <= '0;
            r_src   <= '0;
            r_off   <= '0;
            r_idx   <= '0;
        end else if (w_enq) begin
            r_full  <= 1'b1;
            r_grant <= w_win;
            r_vs    <= io_in_bits_vs[int'(w_win)*VS_W +: VS_W];
            r_src   <= io_in_bits_readSource[int'(w_win)*SRC_W +: SRC_W];
            r_off   <= io_in_bits_offset[int'(w_win)*OFF_W +: OFF_W];
            r_idx   <= io_in_bits_instructionIndex[int'(w_win)*IDX_W +: IDX_W];
            if (int'(w_win) == N_IN - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_win + 1'b1;
            end
        end else if (r_full && io_out_ready) begin
            r_full <= 1'b0;
        end
    end

`ifdef VRF_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles the slot is held by downstream backpressure.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (r_full && !io_out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign io_stall_count = r_stall_cnt;
`endif

    assign io_out_valid                 = r_full;
    assign io_out_grant                 = r_grant;
    assign io_out_bits_vs               = r_vs;
    assign io_out_bits_readSource       = r_src;
    assign io_out_bits_offset           = r_off;
    assign io_out_bits_instructionIndex = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_vrf_read_request_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vrf_read_request_rr_arbiter
// Description : Directed scoreboard bench for vrf_read_request_rr_arbiter
//               (N_IN=4). Optional stall counter checks under
//               VRF_ARB_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vrf_read_request_rr_arbiter;

    typedef struct packed {
        logic [1:0] grant;
        logic [4:0] vs;
        logic [1:0] src;
        logic [5:0] off;
        logic [2:0] idx;
    } txn_t;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [19:0] in_vs;
    logic [7:0]  in_src;
    logic [23:0] in_off;
    logic [11:0] in_idx;
    logic        out_ready;
    logic        out_valid;
    logic [4:0]  out_vs;
    logic [1:0]  out_src;
    logic [5:0]  out_off;
    logic [2:0]  out_idx;
    logic [1:0]  out_grant;
`ifdef VRF_ARB_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int   checks = 0;
    int   errors = 0;
    txn_t sb[$];

    vrf_read_request_rr_arbiter dut (
        .clock                        (clk),
        .reset                        (reset),
        .io_in_valid                  (in_valid),
        .io_in_ready                  (in_ready),
        .io_in_bits_vs                (in_vs),
        .io_in_bits_readSource        (in_src),
        .io_in_bits_offset            (in_off),
        .io_in_bits_instructionIndex  (in_idx),
        .io_out_ready                 (out_ready),
        .io_out_valid                 (out_valid),
        .io_out_bits_vs               (out_vs),
        .io_out_bits_readSource       (out_src),
        .io_out_bits_offset           (out_off),
        .io_out_bits_instructionIndex (out_idx),
`ifdef VRF_ARB_STALL_CNT_EN
        .io_stall_count               (stall_count),
`endif
        .io_out_grant                 (out_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-channel payload pattern; tag varies per step so every beat is distinct.
    function automatic txn_t model(input int tag, input int ch);
        txn_t t;
        t.grant = 2'(ch);
        t.vs    = 5'(tag + ch);
        t.src   = 2'(ch);
        t.off   = 6'(tag * 2 + ch);
        t.idx   = 3'(tag + ch);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus after the edge, then check the combinational
    // accept and the slot valid; record the expected beat for the monitor.
    task automatic step(input logic rst_n, input logic [3:0] valid, input logic ordy,
                        input int tag, input logic [3:0] exp_rdy, input logic exp_val);
        txn_t t;
        @(posedge clk);
        #2;
        reset     = rst_n;
        in_valid  = valid;
        out_ready = ordy;
        for (int ch = 0; ch < 4; ch++) begin
            t = model(tag, ch);
            in_vs[ch*5 +: 5]  = t.vs;
            in_src[ch*2 +: 2] = t.src;
            in_off[ch*6 +: 6] = t.off;
            in_idx[ch*3 +: 3] = t.idx;
        end
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_val));
        if (!rst_n) begin
            sb.delete();
        end
        for (int ch = 0; ch < 4; ch++) begin
            if (exp_rdy[ch] && rst_n) begin
                sb.push_back(model(tag, ch));
            end
        end
    endtask

    // Monitor: pop and compare on each output handshake; check hold under stall.
    initial begin
        txn_t cur;
        txn_t snap;
        txn_t exp;
        logic armed;
        armed = 1'b0;
        snap  = '0;
        forever begin
            @(negedge clk);
            cur = {out_grant, out_vs, out_src, out_off, out_idx};
            if (armed) begin
                chk("hold", 32'(cur), 32'(snap));
            end
            armed = reset && out_valid && !out_ready;
            snap  = cur;
            if (reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'(cur), 32'hFFFFFFFF);
                end else begin
                    exp = sb.pop_front();
                    chk("beat", 32'(cur), 32'(exp));
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        in_vs     = '0;
        in_src    = '0;
        in_off    = '0;
        in_idx    = '0;

        // Reset and release
        repeat (3) step(1'b0, 4'b0000, 1'b0, 0, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 0, 4'b0000, 1'b0);
        chk("reset_outputs", 32'({out_grant, out_vs, out_src, out_off, out_idx}), 32'd0);
`ifdef VRF_ARB_STALL_CNT_EN
        chk("reset_stall_count", 32'(stall_count), 32'd0);
`endif

        // Round robin with all channels valid, full throughput
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b1111, 1'b1, 1 + i, 4'(1 << (i % 4)), (i != 0));
        end
        step(1'b1, 4'b0000, 1'b1, 0, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1, 0, 4'b0000, 1'b0);

        // Skip and wrap: ch2 leaves ptr=3, then 0101 -> ch0, then ch2
        step(1'b1, 4'b0100, 1'b1, 10, 4'b0100, 1'b0);
        step(1'b1, 4'b0101, 1'b1, 11, 4'b0001, 1'b1);
        step(1'b1, 4'b0101, 1'b1, 12, 4'b0100, 1'b1);
        step(1'b1, 4'b0000, 1'b1, 0, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1, 0, 4'b0000, 1'b0);

        // Backpressure: slot holds vs=17 for 5 stalled cycles
        step(1'b1, 4'b0001, 1'b0, 17, 4'b0001, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b0001, 1'b0, 17, 4'b0000, 1'b1);
            chk("stall_vs", 32'(out_vs), 32'd17);
        end

        // Simultaneous dequeue and enqueue of ch2 with offset 42
        step(1'b1, 4'b0100, 1'b1, 20, 4'b0100, 1'b1);
`ifdef VRF_ARB_STALL_CNT_EN
        chk("stall_count", 32'(stall_count), 32'd5);
`endif
        step(1'b1, 4'b0000, 1'b0, 0, 4'b0000, 1'b1);
        chk("simul_offset", 32'(out_off), 32'd42);
        chk("simul_grant", 32'(out_grant), 32'd2);

        // Reset while full: request dropped, ptr cleared
        step(1'b0, 4'b1111, 1'b0, 0, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b0, 0, 4'b0000, 1'b0);
        chk("midreset_vs", 32'(out_vs), 32'd0);
`ifdef VRF_ARB_STALL_CNT_EN
        chk("midreset_stall_count", 32'(stall_count), 32'd0);
`endif
        step(1'b1, 4'b1000, 1'b1, 5, 4'b1000, 1'b0);
        step(1'b1, 4'b0010, 1'b1, 6, 4'b0010, 1'b1);

        // Second reset with ptr=2; 1010 must then pick ch1 from ptr=0
        step(1'b0, 4'b0000, 1'b1, 0, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1, 0, 4'b0000, 1'b0);
        step(1'b1, 4'b1010, 1'b1, 7, 4'b0010, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 0, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1, 0, 4'b0000, 1'b0);

        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vrf_read_request_rr_arbiter.md
VRF_READ_REQUEST_RR_ARBITER -- requirements
Module: vrf_read_request_rr_arbiter

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of request channels, legal range 1..16.
REQ-002 SHALL have parameter VS_W, default 5: width of the vs field.
REQ-003 SHALL have parameter SRC_W, default 2: width of the readSource field.
REQ-004 SHALL have parameter OFF_W, default 6: width of the offset field.
REQ-005 SHALL have parameter IDX_W, default 3: width of the instructionIndex field.
REQ-006 SHALL have port clock, input, 1: single clock, all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port io_in_valid, input, N_IN: per-channel request valid.
REQ-009 SHALL have port io_in_ready, output, N_IN: per-channel accept.
REQ-010 SHALL have ports io_in_bits_vs / _readSource / _offset / _instructionIndex, inputs, N_IN*VS_W / N_IN*SRC_W / N_IN*OFF_W / N_IN*IDX_W: packed per-channel fields, channel i at slice [i*W +: W].
REQ-011 SHALL have port io_out_ready, input, 1: downstream accept.
REQ-012 SHALL have port io_out_valid, output, 1: registered request present.
REQ-013 SHALL have ports io_out_bits_vs / _readSource / _offset / _instructionIndex, outputs, VS_W / SRC_W / OFF_W / IDX_W: registered winning request.
REQ-014 SHALL have port io_out_grant, output, GW = max(1, clog2(N_IN)): index of the channel that supplied the registered request.

Function
REQ-015 SHALL hold one output slot with state full, payload and grant index; io_out_valid = full.
REQ-016 SHALL compute enq_ready = !full || io_out_ready.
REQ-017 SHALL select as winner the first channel with io_in_valid=1 in the order ptr, ptr+1, ..., N_IN-1, 0, ..., ptr-1.
REQ-018 SHALL drive io_in_ready[i]=1 only for the winner, and only when enq_ready=1; all other bits of io_in_ready SHALL be 0.
REQ-019 SHALL enqueue on io_in_valid[w] && io_in_ready[w]: full<=1, payload<=channel w fields, grant<=w, ptr<=(w+1) mod N_IN.
REQ-020 SHALL leave ptr unchanged on any cycle with no enqueue.
REQ-021 SHALL wrap ptr from N_IN-1 to 0 on a winner of N_IN-1.
REQ-022 SHALL set full<=0 on a dequeue (full && io_out_ready) with no simultaneous enqueue.
REQ-023 SHALL, on simultaneous dequeue and enqueue, replace the payload and keep full=1, sustaining 1 request/cycle.
REQ-024 SHALL give a latency of exactly 1 cycle from the accepting edge to io_out_valid=1.
REQ-025 SHALL hold io_out_bits_* and io_out_grant stable while io_out_valid && !io_out_ready.
REQ-026 SHALL grant every continuously-valid channel within N_IN consecutive enqueues (fairness).
REQ-027 SHALL, for N_IN=1, make io_in_ready[0]=enq_ready, keep ptr and io_out_grant at 0, and act as a 1-entry pipe stage.
REQ-028 SHALL keep ready combinational from io_in_valid and io_out_ready, and SHALL NOT feed io_in_ready back into valid.

Reset
REQ-029 SHALL, on a clock edge with reset=0, clear full, ptr, payload, grant and the stall counter to 0, so io_out_valid=0 and all io_out_bits_*=0.
REQ-030 SHALL drive io_in_ready to all-0 while reset=0, and SHALL drop any request in flight mid-operation without delivering it.

Configuration
REQ-031 SHALL gate the stall counter with macro VRF_ARB_STALL_CNT_EN.
REQ-032 SHALL, with VRF_ARB_STALL_CNT_EN defined, add output io_stall_count (16 bits): increments each cycle io_out_valid && !io_out_ready, saturates at 0xFFFF, clears on reset.
REQ-033 SHALL, without VRF_ARB_STALL_CNT_EN, omit the io_stall_count port and counter; all other behaviour SHALL be identical.

Verification
REQ-034 Bench SHALL cover reset release: after reset high, io_out_valid=0, io_in_ready=4'b0000 with all valid low, and outputs all zero.
REQ-035 Bench SHALL cover round-robin: N_IN=4, io_in_valid=4'b1111, io_out_ready=1 for 8 cycles -> io_out_grant sequence 0,1,2,3,0,1,2,3, one per cycle, lagging the accept by 1 cycle.
REQ-036 Bench SHALL cover skip and wrap: ptr=3, io_in_valid=4'b0101 -> winner 0 (io_in_ready=4'b0001), ptr becomes 1; next cycle winner 2.
REQ-037 Bench SHALL cover backpressure: slot full with vs=5'd17, io_out_ready=0 for 5 cycles -> io_in_ready=0, vs held 17, io_stall_count=5 (macro defined).
REQ-038 Bench SHALL cover simultaneous dequeue and enqueue: full, io_out_ready=1, channel 2 valid with offset=6'd42 -> next cycle io_out_valid=1, offset=42, grant=2, with no bubble.
REQ-039 Bench SHALL cover reset mid-operation: reset=0 asserted while full -> next cycle io_out_valid=0, ptr=0; after release, io_in_valid=4'b1000 is granted channel 3 first.
